mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the two cache ports, the arbiter and the memory-fetch unit.
// The slave modport is the arbiter's view; master is the view of whatever drives the caches and memory.
interface mem_arbiter_if #(
    parameter int WORDSZ  = 64,
    parameter int BLOCKSZ = 512
);
    logic               i_req;
    logic [WORDSZ-1:0]  i_addr;
    logic               i_valid;
    logic [BLOCKSZ-1:0] i_data;

    logic               d_req;
    logic [WORDSZ-1:0]  d_addr;
    logic               d_valid;
    logic [BLOCKSZ-1:0] d_data;

    logic [WORDSZ-1:0]  mem_address;
    logic               mem_start_req;
    logic [BLOCKSZ-1:0] mem_data_in;
    logic               mem_data_valid;

    // Valid/ready contract: a requester raises req with a stable addr and keeps both until its
    // one-cycle valid pulse, dropping req at the edge that samples valid=1. The memory side
    // receives a one-cycle mem_start_req and answers with a one-cycle mem_data_valid.
    modport slave (
        input  i_req, i_addr, d_req, d_addr, mem_data_in, mem_data_valid,
        output i_valid, i_data, d_valid, d_data, mem_address, mem_start_req
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, mem_data_in, mem_data_valid,
        input  i_valid, i_data, d_valid, d_data, mem_address, mem_start_req
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) line-read arbiter in front of a single memory-fetch unit.
// Round-robin on contention, one outstanding transaction, all outputs registered.
module mem_arbiter #(
    parameter int WORDSZ  = 64,
    parameter int BLOCKSZ = 512
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         busy,
    output logic         grant_id,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [WORDSZ-1:0] LINE_MASK = ~(WORDSZ'(6'h3f));

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic [WORDSZ-1:0]  mem_address_q, mem_address_d;
    logic               mem_start_q, mem_start_d;
    logic               i_valid_q, i_valid_d;
    logic               d_valid_q, d_valid_d;
    logic [BLOCKSZ-1:0] line_q, line_d;

    logic               any_req;
    logic               winner;
    logic [WORDSZ-1:0]  winner_addr;

    // On contention the port that did not win last time goes next; a lone requester always wins.
    always_comb begin
        any_req     = bus.i_req | bus.d_req;
        winner      = (bus.i_req && bus.d_req) ? ~last_grant_q : bus.d_req;
        winner_addr = winner ? bus.d_addr : bus.i_addr;
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        mem_address_d = mem_address_q;
        mem_start_d   = 1'b0;
        i_valid_d     = 1'b0;
        d_valid_d     = 1'b0;
        line_d        = line_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d       = ISSUE;
                    last_grant_d  = winner;
                    grant_id_d    = winner;
                    busy_d        = 1'b1;
                    mem_address_d = winner_addr & LINE_MASK;
                    mem_start_d   = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // No timeout: the fetch unit is trusted to answer eventually.
                if (bus.mem_data_valid) begin
                    state_d       = RESP;
                    line_d        = bus.mem_data_in;
                    mem_address_d = '0;
                    i_valid_d     = ~grant_id_q;
                    d_valid_d     = grant_id_q;
                end
            end
            RESP: begin
                state_d    = IDLE;
                grant_id_d = 1'b0;
                busy_d     = 1'b0;
            end
            default: begin
                state_d       = IDLE;
                grant_id_d    = 1'b0;
                busy_d        = 1'b0;
                mem_address_d = '0;
            end
        endcase
    end

    // Reset abandons any transaction in flight, including the captured line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            busy_q        <= 1'b0;
            mem_address_q <= '0;
            mem_start_q   <= 1'b0;
            i_valid_q     <= 1'b0;
            d_valid_q     <= 1'b0;
            line_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            mem_address_q <= mem_address_d;
            mem_start_q   <= mem_start_d;
            i_valid_q     <= i_valid_d;
            d_valid_q     <= d_valid_d;
            line_q        <= line_d;
        end
    end

    assign bus.i_valid       = i_valid_q;
    assign bus.d_valid       = d_valid_q;
    assign bus.i_data        = line_q;
    assign bus.d_data        = line_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_start_req = mem_start_q;
    assign busy              = busy_q;
    assign grant_id          = grant_id_q;
    assign dbg_state         = state_q;

    a_one_valid: assert property (@(posedge clk) disable iff (reset)
        !(i_valid_q && d_valid_q));
    a_start_in_issue: assert property (@(posedge clk) disable iff (reset)
        mem_start_q == (state_q == ISSUE));
    a_valid_in_resp: assert property (@(posedge clk) disable iff (reset)
        (i_valid_q || d_valid_q) |-> (state_q == RESP));
    a_busy_not_idle: assert property (@(posedge clk) disable iff (reset)
        busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, each checking its own expectations.
module tb_mem_arbiter;
    localparam int WORDSZ  = 64;
    localparam int BLOCKSZ = 512;

    localparam logic [BLOCKSZ-1:0] PAT_A = {64{8'haa}};
    localparam logic [BLOCKSZ-1:0] PAT_B = {64{8'h5a}};
    localparam logic [BLOCKSZ-1:0] PAT_C = {64{8'hc3}};
    localparam logic [BLOCKSZ-1:0] PAT_D = {64{8'h17}};
    localparam logic [BLOCKSZ-1:0] PAT_S = {64{8'h55}};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic       grant_id;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    logic grant_log[$];
    logic exp_q[$];

    mem_arbiter_if #(.WORDSZ(WORDSZ), .BLOCKSZ(BLOCKSZ)) bus();

    mem_arbiter #(.WORDSZ(WORDSZ), .BLOCKSZ(BLOCKSZ)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .busy      (busy),
        .grant_id  (grant_id),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // passive monitor on the falling edge
    always @(negedge clk) begin
        if (bus.i_valid) i_pulses++;
        if (bus.d_valid) d_pulses++;
        if (bus.mem_start_req) grant_log.push_back(grant_id);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req          = 1'b0;
        bus.i_addr         = '0;
        bus.d_req          = 1'b0;
        bus.d_addr         = '0;
        bus.mem_data_in    = '0;
        bus.mem_data_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %0b want 0", grant_id); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        checks++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valids: got i=%0b d=%0b want 0 0", bus.i_valid, bus.d_valid); end
        checks++; if (bus.mem_start_req !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b want 0", bus.mem_start_req); end
        checks++; if (bus.mem_address !== 64'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", bus.mem_address); end
        checks++; if (bus.i_data !== '0 || bus.d_data !== '0) begin
            errors++; $display("FAIL reset_line: got i=%h want 0", bus.i_data); end
        reset = 1'b0;
        tick();
        checks++; if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: got state=%0d busy=%0b want 0 0", dbg_state, busy); end
    endtask

    task automatic test_single_icache();
        int i0, d0;
        i0 = i_pulses;
        d0 = d_pulses;
        bus.i_addr = 64'h1047;
        bus.i_req  = 1'b1;
        tick();
        checks++; if (bus.mem_start_req !== 1'b1) begin errors++; $display("FAIL single_start_c1: got %0b want 1", bus.mem_start_req); end
        checks++; if (bus.mem_address !== 64'h1040) begin errors++; $display("FAIL single_addr_c1: got %h want 1040", bus.mem_address); end
        checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_grant_c1: got gid=%0b busy=%0b want 0 1", grant_id, busy); end
        tick();
        checks++; if (bus.mem_start_req !== 1'b0 || dbg_state !== 2'd2) begin
            errors++; $display("FAIL single_wait_c2: got start=%0b state=%0d want 0 2", bus.mem_start_req, dbg_state); end
        checks++; if (bus.mem_address !== 64'h1040) begin errors++; $display("FAIL single_addr_c2: got %h want 1040", bus.mem_address); end
        tick();
        tick();
        tick();
        checks++; if (dbg_state !== 2'd2 || bus.i_valid !== 1'b0) begin
            errors++; $display("FAIL single_still_wait_c5: got state=%0d iv=%0b want 2 0", dbg_state, bus.i_valid); end
        bus.mem_data_in    = PAT_A;
        bus.mem_data_valid = 1'b1;
        tick();
        checks++; if (bus.i_valid !== 1'b1 || bus.d_valid !== 1'b0) begin
            errors++; $display("FAIL single_valid_c6: got i=%0b d=%0b want 1 0", bus.i_valid, bus.d_valid); end
        checks++; if (bus.i_data !== PAT_A) begin errors++; $display("FAIL single_data_c6: got %h want %h", bus.i_data, PAT_A); end
        checks++; if (bus.mem_address !== 64'h0) begin errors++; $display("FAIL single_addr_resp: got %h want 0", bus.mem_address); end
        bus.i_req          = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = '0;
        tick();
        checks++; if (bus.i_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL single_idle_c7: got iv=%0b busy=%0b state=%0d want 0 0 0", bus.i_valid, busy, dbg_state); end
        checks++; if (bus.i_data !== PAT_A) begin errors++; $display("FAIL single_data_hold: got %h want %h", bus.i_data, PAT_A); end
        checks++; if (i_pulses - i0 !== 1 || d_pulses - d0 !== 0) begin
            errors++; $display("FAIL single_pulse_count: got i=%0d d=%0d want 1 0", i_pulses - i0, d_pulses - d0); end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        bus.i_addr = 64'h100;
        bus.d_addr = 64'h200;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        tick();
        checks++; if (grant_id !== 1'b0 || bus.mem_address !== 64'h100) begin
            errors++; $display("FAIL simul_first_grant: got gid=%0b addr=%h want 0 100", grant_id, bus.mem_address); end
        tick();
        bus.mem_data_in    = PAT_B;
        bus.mem_data_valid = 1'b1;
        tick();
        checks++; if (bus.i_valid !== 1'b1 || bus.d_valid !== 1'b0) begin
            errors++; $display("FAIL simul_ivalid_c3: got i=%0b d=%0b want 1 0", bus.i_valid, bus.d_valid); end
        bus.i_req          = 1'b0;
        bus.mem_data_valid = 1'b0;
        tick();
        checks++; if (dbg_state !== 2'd0 || busy !== 1'b0 || grant_id !== 1'b0) begin
            errors++; $display("FAIL simul_gap_idle: got state=%0d busy=%0b gid=%0b want 0 0 0", dbg_state, busy, grant_id); end
        tick();
        checks++; if (grant_id !== 1'b1 || bus.mem_start_req !== 1'b1 || bus.mem_address !== 64'h200) begin
            errors++; $display("FAIL simul_second_grant: got gid=%0b start=%0b addr=%h want 1 1 200", grant_id, bus.mem_start_req, bus.mem_address); end
        tick();
        bus.mem_data_in    = PAT_C;
        bus.mem_data_valid = 1'b1;
        tick();
        checks++; if (bus.d_valid !== 1'b1 || bus.i_valid !== 1'b0 || bus.d_data !== PAT_C) begin
            errors++; $display("FAIL simul_dvalid: got d=%0b i=%0b data=%h want 1 0 %h", bus.d_valid, bus.i_valid, bus.d_data, PAT_C); end
        checks++; if (bus.i_data !== PAT_C) begin errors++; $display("FAIL simul_shared_line: got %h want %h", bus.i_data, PAT_C); end
        bus.d_req          = 1'b0;
        bus.mem_data_valid = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int base, i0, d0;
        base = grant_log.size();
        i0   = i_pulses;
        d0   = d_pulses;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus.i_addr = 64'h1000;
        bus.d_addr = 64'h2000;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int wait_n;
            logic [7:0] tb8;
            wait_n = 0;
            tb8    = 8'(t);
            while (bus.mem_start_req !== 1'b1 && wait_n < 20) begin
                tick();
                wait_n++;
            end
            checks++; if (wait_n >= 20) begin errors++; $display("FAIL rr_start_timeout: txn %0d got no start in 20 cycles", t); end
            tick();
            bus.mem_data_in    = {64{tb8}};
            bus.mem_data_valid = 1'b1;
            tick();
            bus.mem_data_valid = 1'b0;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        tick();
        checks++; if (grant_log.size() - base !== 4) begin
            errors++; $display("FAIL rr_grant_count: got %0d want 4", grant_log.size() - base); end
        for (int k = 0; k < 4; k++) begin
            if (base + k < grant_log.size()) begin
                checks++; if (grant_log[base + k] !== exp_q[k]) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0b want %0b", k, grant_log[base + k], exp_q[k]); end
            end
        end
        checks++; if (i_pulses - i0 !== 2 || d_pulses - d0 !== 2) begin
            errors++; $display("FAIL rr_pulses: got i=%0d d=%0d want 2 2", i_pulses - i0, d_pulses - d0); end
    endtask

    task automatic test_spurious();
        int i0, d0;
        logic [BLOCKSZ-1:0] line_before;
        logic [7:0] last_byte;
        last_byte   = 8'd3;
        line_before = {64{last_byte}};
        i0 = i_pulses;
        d0 = d_pulses;
        bus.mem_data_in    = PAT_S;
        bus.mem_data_valid = 1'b1;
        tick();
        checks++; if (dbg_state !== 2'd0 || busy !== 1'b0 || bus.i_data !== line_before) begin
            errors++; $display("FAIL spur_idle: got state=%0d busy=%0b line=%h", dbg_state, busy, bus.i_data); end
        bus.d_addr = 64'h7777;
        bus.d_req  = 1'b1;
        tick();
        checks++; if (dbg_state !== 2'd1 || bus.d_data !== line_before) begin
            errors++; $display("FAIL spur_issue_entry: got state=%0d line=%h want 1 unchanged", dbg_state, bus.d_data); end
        tick();
        checks++; if (dbg_state !== 2'd2 || bus.d_valid !== 1'b0 || bus.d_data !== line_before) begin
            errors++; $display("FAIL spur_issue_ignored: got state=%0d dv=%0b line=%h want 2 0 unchanged", dbg_state, bus.d_valid, bus.d_data); end
        bus.mem_data_in = PAT_D;
        tick();
        checks++; if (bus.d_valid !== 1'b1 || bus.d_data !== PAT_D) begin
            errors++; $display("FAIL spur_then_normal: got dv=%0b data=%h want 1 %h", bus.d_valid, bus.d_data, PAT_D); end
        bus.d_req          = 1'b0;
        bus.mem_data_valid = 1'b0;
        tick();
        checks++; if (i_pulses - i0 !== 0 || d_pulses - d0 !== 1) begin
            errors++; $display("FAIL spur_pulses: got i=%0d d=%0d want 0 1", i_pulses - i0, d_pulses - d0); end
    endtask

    task automatic test_reset_in_wait();
        int i0, d0;
        i0 = i_pulses;
        d0 = d_pulses;
        bus.i_addr = 64'h4000;
        bus.i_req  = 1'b1;
        tick();
        tick();
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rstw_in_wait: got %0d want 2", dbg_state); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || bus.mem_address !== 64'h0 || bus.i_data !== '0) begin
            errors++; $display("FAIL rstw_async_clear: got busy=%0b addr=%h line=%h", busy, bus.mem_address, bus.i_data); end
        tick();
        reset              = 1'b0;
        bus.i_req          = 1'b0;
        bus.mem_data_in    = PAT_A;
        bus.mem_data_valid = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || dbg_state !== 2'd0 || bus.i_data !== '0) begin
            errors++; $display("FAIL rstw_stale_data: got busy=%0b state=%0d line=%h", busy, dbg_state, bus.i_data); end
        bus.mem_data_valid = 1'b0;
        tick();
        checks++; if (i_pulses - i0 !== 0 || d_pulses - d0 !== 0) begin
            errors++; $display("FAIL rstw_no_pulse: got i=%0d d=%0d want 0 0", i_pulses - i0, d_pulses - d0); end
        bus.d_addr = 64'h5055;
        bus.d_req  = 1'b1;
        tick();
        checks++; if (grant_id !== 1'b1 || bus.mem_address !== 64'h5040 || bus.mem_start_req !== 1'b1) begin
            errors++; $display("FAIL rstw_new_grant: got gid=%0b addr=%h start=%0b want 1 5040 1", grant_id, bus.mem_address, bus.mem_start_req); end
        tick();
        bus.mem_data_in    = PAT_B;
        bus.mem_data_valid = 1'b1;
        tick();
        checks++; if (bus.d_valid !== 1'b1 || bus.d_data !== PAT_B || bus.i_valid !== 1'b0) begin
            errors++; $display("FAIL rstw_new_resp: got dv=%0b iv=%0b data=%h", bus.d_valid, bus.i_valid, bus.d_data); end
        bus.d_req          = 1'b0;
        bus.mem_data_valid = 1'b0;
        tick();
    endtask

    task automatic test_addr_stable();
        bus.i_addr = 64'h2000;
        bus.i_req  = 1'b1;
        tick();
        tick();
        bus.i_addr = 64'h3000;
        tick();
        checks++; if (bus.mem_address !== 64'h2000) begin errors++; $display("FAIL addr_stable_w1: got %h want 2000", bus.mem_address); end
        tick();
        checks++; if (bus.mem_address !== 64'h2000 || dbg_state !== 2'd2) begin
            errors++; $display("FAIL addr_stable_w2: got addr=%h state=%0d want 2000 2", bus.mem_address, dbg_state); end
        bus.mem_data_in    = PAT_C;
        bus.mem_data_valid = 1'b1;
        tick();
        checks++; if (bus.i_valid !== 1'b1 || bus.mem_address !== 64'h0) begin
            errors++; $display("FAIL addr_stable_resp: got iv=%0b addr=%h want 1 0", bus.i_valid, bus.mem_address); end
        bus.i_req          = 1'b0;
        bus.mem_data_valid = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_icache();
        test_simultaneous();
        test_round_robin();
        test_spurious();
        test_reset_in_wait();
        test_addr_stable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
